cmos_capture_crop: RTL and testbench
====================================

Name: cmos_capture_crop

Overview:
Parametrised successor to the camera capture and tailor path. It samples the CMOS DVP bus and assembles multi-byte pixels. It skips the first SKIP_FRAMES unstable frames after reset, then applies a runtime-programmable crop window instead of a fixed per-LCD-ID tailor. Output feeds the DDR3 write FIFO, with the resulting frame size and max address for the DDR3 controller.

Parameters:
- DATA_W, 8, CMOS data bus width.
- BYTES_PER_PIX, 2, bus beats per pixel (1..4).
- PIX_W, 16, output pixel width; must equal DATA_W*BYTES_PER_PIX.
- CNT_W, 11, width of x/y counters and window fields.
- ADDR_W, 28, width of ddr3_addr_max.
- SKIP_FRAMES, 10, frames discarded after reset (0 allowed).

Ports:
- cam_pclk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cam_vsync  in  1  frame sync, active high; rising edge = frame start.
- cam_href  in  1  line valid, active high.
- cam_data  in  DATA_W  camera data.
- crop_en  in  1  1 = apply window, 0 = pass full frame.
- h_start  in  CNT_W  first kept column.
- v_start  in  CNT_W  first kept line.
- crop_w  in  CNT_W  window width in pixels.
- crop_h  in  CNT_W  window height in lines.
- h_pixel  out  CNT_W  effective output width of the current frame.
- v_pixel  out  CNT_W  effective output height of the current frame.
- ddr3_addr_max  out  ADDR_W  h_pixel*v_pixel.
- cmos_frame_vsync  out  1  registered vsync, gated until the skip completes.
- cmos_frame_href  out  1  registered href, gated until the skip completes.
- cmos_frame_valid  out  1  one-cycle pixel strobe.
- cmos_frame_data  out  PIX_W  assembled pixel; first beat in MSBs.
- frame_done  out  1  one-cycle pulse at the start of the frame following a captured frame.

Behaviour:
- Reset: all outputs 0. h_pixel, v_pixel and ddr3_addr_max are 0 until the first frame start after the skip completes. Counters, state and assembly registers are cleared. Reset mid-frame aborts the frame; capture resumes at the next vsync rising edge after SKIP again.
- Input stage: vsync, href and data are registered once (stage d1). Edges are detected on d1 against d2.
- FSM states:
  - SKIP: count vsync rising edges. Go to IDLE once count == SKIP_FRAMES. With SKIP_FRAMES = 0, go to IDLE on the first cycle after reset.
  - IDLE: wait for a vsync rising edge, then go to CAPT.
  - CAPT: capture the frame. Each later vsync rising edge pulses frame_done and stays in CAPT.
- Config latching: crop_en, h_start, v_start, crop_w and crop_h are latched on every vsync rising edge in IDLE or CAPT. Changes mid-frame have no effect until the next frame. h_pixel, v_pixel and ddr3_addr_max update on the same edge: the crop values if crop_en is latched as 1, otherwise the size measured over the previous frame (pixels per line, lines). The product is zero-extended to ADDR_W.
- Assembly: beat counter runs 0..BYTES_PER_PIX-1 while href_d1 is high, shifting data in MSB-first. On the last beat, pixel x is complete and registered. cmos_frame_valid is high exactly one cycle, two cycles after the last beat appears on cam_data.
- Partial pixel at href falling edge: discarded, no strobe. The beat counter resets at every href falling edge.
- Counters:
  - x counts complete pixels in the line; cleared on href rising edge.
  - y counts lines; increments on href falling edge and clears at frame start.
  - Both saturate at all-ones; no wrap.
- Window: a pixel is kept when x >= h_start, x < h_start+crop_w, y >= v_start and y < v_start+crop_h. Sums are computed at CNT_W+1 bits so the compare cannot overflow.
  - A window beyond the sensor frame is truncated; no error is raised.
  - crop_w = 0 or crop_h = 0 means no strobes for the frame.
- crop_en latched 0: every complete pixel is strobed.
- cmos_frame_vsync and cmos_frame_href follow d1 delayed to align with the valid strobe. Both are held 0 in SKIP.

Optional Feature:
- CROP_STATS_EN defined:
  - Adds output pix_cnt (2*CNT_W bits): pixels strobed in the last frame, updated at frame_done.
  - Adds output size_err (1 bit): high for the following frame when pix_cnt != h_pixel*v_pixel with crop_en = 1, meaning the window exceeded the sensor frame or a line was short.
- CROP_STATS_EN undefined: neither port nor its logic exists.

Test Plan:
- SKIP_FRAMES = 2, three 4x3 frames of 16-bit pixels -> no valid strobes, cmos_frame_vsync and cmos_frame_href low in frames 1 and 2. 12 strobes in frame 3, data = {first byte, second byte}.
- crop_en = 1, h_start = 2, v_start = 1, crop_w = 3, crop_h = 2 on a 8x4 frame -> exactly 6 strobes: columns 2..4 of lines 1..2. h_pixel = 3, v_pixel = 2, ddr3_addr_max = 6.
- Window changed mid-frame -> the current frame still uses the old window; the new window applies from the next vsync rising edge.
- href drops after an odd byte count (5 bytes, BYTES_PER_PIX = 2) -> 2 strobes; the partial byte does not corrupt the first pixel of the next line.
- crop_en = 0 with a 640x480 frame -> h_pixel = 640, v_pixel = 480 and ddr3_addr_max = 307200 from the next frame; frame_done pulses once per frame start.
- rst_n asserted mid-line -> all outputs 0 immediately; after release the block re-skips SKIP_FRAMES frames. With CROP_STATS_EN, a 4x4 window on a 3x3 frame gives pix_cnt = 9 and size_err = 1.

Source files
------------

// File: rtl/cmos_capture_crop.sv
// cmos_capture_crop
//   Samples a CMOS DVP bus, assembles BYTES_PER_PIX beats into one pixel
//   (first beat in the MSBs), discards the first SKIP_FRAMES frames after
//   reset, then streams pixels through a crop window that is latched at each
//   frame start. The effective frame size and DDR3 max address are
//   published at every frame start once capture is running.
//
//   Optional build macro: CROP_STATS_EN adds pix_cnt / size_err.
//
// Ports
//   cam_pclk, rst_n          pixel clock (rising edge), async active-low reset
//   cam_vsync/href/data      raw DVP bus
//   crop_en, h_start, v_start, crop_w, crop_h
//                            crop window, sampled at frame start
//   h_pixel, v_pixel         effective output size of the current frame
//   ddr3_addr_max            h_pixel * v_pixel, zero-extended
//   cmos_frame_vsync/href    delayed sync, aligned with cmos_frame_valid
//   cmos_frame_valid/data    one-cycle pixel strobe and assembled pixel
//   frame_done               pulse at the start of a frame following a captured one
//   pix_cnt, size_err        (CROP_STATS_EN) strobes in last frame, window/size mismatch
module cmos_capture_crop #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int PIX_W         = 16,
  parameter int CNT_W         = 11,
  parameter int ADDR_W        = 28,
  parameter int SKIP_FRAMES   = 10
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              crop_en,
  input  logic [CNT_W-1:0]  h_start,
  input  logic [CNT_W-1:0]  v_start,
  input  logic [CNT_W-1:0]  crop_w,
  input  logic [CNT_W-1:0]  crop_h,
  output logic [CNT_W-1:0]  h_pixel,
  output logic [CNT_W-1:0]  v_pixel,
  output logic [ADDR_W-1:0] ddr3_addr_max,
  output logic              cmos_frame_vsync,
  output logic              cmos_frame_href,
  output logic              cmos_frame_valid,
  output logic [PIX_W-1:0]  cmos_frame_data,
  output logic              frame_done
`ifdef CROP_STATS_EN
  ,
  output logic [2*CNT_W-1:0] pix_cnt,
  output logic               size_err
`endif
);

  localparam logic [1:0] ST_SKIP = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  localparam int BCW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int PRW = 2 * CNT_W;

  logic              vsync_d1, vsync_d2;
  logic              href_d1, href_d2;
  logic [DATA_W-1:0] data_d1;

  logic [1:0]        state;
  logic [SKW-1:0]    skip_cnt;

  logic [BCW-1:0]    beat_cnt;
  logic [PIX_W-1:0]  shift_reg;

  logic [CNT_W-1:0]  x_cnt, y_cnt, meas_w;

  logic              crop_en_l;
  logic [CNT_W-1:0]  h_start_l, v_start_l, crop_w_l, crop_h_l;

  logic              vsync_rise, href_rise, href_fall;
  logic              beat_last;
  logic [PIX_W+DATA_W-1:0] shift_cat;
  logic [PIX_W-1:0]  pix_next;
  logic [CNT_W-1:0]  x_idx, x_inc, y_inc;
  logic [CNT_W:0]    h_end, v_end;
  logic              in_x, in_y, keep;
  logic              cap_open, cfg_load, pix_fire;
  logic [CNT_W-1:0]  nxt_h, nxt_v;
  logic [PRW-1:0]    prod;
  logic [ADDR_W+PRW-1:0] prod_ext;

  assign vsync_rise = vsync_d1 & ~vsync_d2;
  assign href_rise  = href_d1 & ~href_d2;
  assign href_fall  = ~href_d1 & href_d2;

  assign beat_last  = href_d1 && (beat_cnt == BCW'(BYTES_PER_PIX - 1));

  // Exactly BYTES_PER_PIX shifts fill the pixel, so leftovers from a
  // discarded partial pixel are always pushed out before the next strobe.
  assign shift_cat  = {shift_reg, data_d1};
  assign pix_next   = shift_cat[PIX_W-1:0];

  // When a line starts with a single-beat pixel the clear and the
  // completion land on the same cycle; index from zero in that case.
  assign x_idx = href_rise ? '0 : x_cnt;
  assign x_inc = (x_idx == '1) ? x_idx : x_idx + CNT_W'(1);
  assign y_inc = (y_cnt == '1) ? y_cnt : y_cnt + CNT_W'(1);

  assign h_end = {1'b0, h_start_l} + {1'b0, crop_w_l};
  assign v_end = {1'b0, v_start_l} + {1'b0, crop_h_l};
  assign in_x  = (x_idx >= h_start_l) && ({1'b0, x_idx} < h_end);
  assign in_y  = (y_cnt >= v_start_l) && ({1'b0, y_cnt} < v_end);
  assign keep  = !crop_en_l || (in_x && in_y);

  // Output path opens on the frame start that moves IDLE into CAPT, so the
  // tail of the frame that completed the skip count stays hidden.
  assign cap_open = (state == ST_CAPT) || ((state == ST_IDLE) && vsync_rise);
  assign cfg_load = vsync_rise && (state != ST_SKIP);
  assign pix_fire = beat_last && keep && cap_open;

  assign nxt_h    = crop_en ? crop_w : meas_w;
  assign nxt_v    = crop_en ? crop_h : y_cnt;
  assign prod     = PRW'(nxt_h) * PRW'(nxt_v);
  assign prod_ext = {{ADDR_W{1'b0}}, prod};

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1         <= 1'b0;
      vsync_d2         <= 1'b0;
      href_d1          <= 1'b0;
      href_d2          <= 1'b0;
      data_d1          <= '0;
      state            <= ST_SKIP;
      skip_cnt         <= '0;
      beat_cnt         <= '0;
      shift_reg        <= '0;
      x_cnt            <= '0;
      y_cnt            <= '0;
      meas_w           <= '0;
      crop_en_l        <= 1'b0;
      h_start_l        <= '0;
      v_start_l        <= '0;
      crop_w_l         <= '0;
      crop_h_l         <= '0;
      h_pixel          <= '0;
      v_pixel          <= '0;
      ddr3_addr_max    <= '0;
      cmos_frame_vsync <= 1'b0;
      cmos_frame_href  <= 1'b0;
      cmos_frame_valid <= 1'b0;
      cmos_frame_data  <= '0;
      frame_done       <= 1'b0;
    end else begin
      vsync_d1 <= cam_vsync;
      vsync_d2 <= vsync_d1;
      href_d1  <= cam_href;
      href_d2  <= href_d1;
      data_d1  <= cam_data;

      case (state)
        ST_SKIP: begin
          if (skip_cnt == SKW'(SKIP_FRAMES)) state <= ST_IDLE;
          else if (vsync_rise) skip_cnt <= skip_cnt + SKW'(1);
        end
        ST_IDLE: if (vsync_rise) state <= ST_CAPT;
        ST_CAPT: state <= ST_CAPT;
        default: state <= ST_SKIP;
      endcase

      if (!href_d1 || beat_last) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + BCW'(1);
      if (href_d1) shift_reg <= pix_next;

      if (beat_last)      x_cnt <= x_inc;
      else if (href_rise) x_cnt <= '0;

      if (vsync_rise)     y_cnt <= '0;
      else if (href_fall) y_cnt <= y_inc;
      if (href_fall)      meas_w <= x_cnt;

      if (cfg_load) begin
        crop_en_l     <= crop_en;
        h_start_l     <= h_start;
        v_start_l     <= v_start;
        crop_w_l      <= crop_w;
        crop_h_l      <= crop_h;
        h_pixel       <= nxt_h;
        v_pixel       <= nxt_v;
        ddr3_addr_max <= prod_ext[ADDR_W-1:0];
      end

      cmos_frame_vsync <= cap_open & vsync_d1;
      cmos_frame_href  <= cap_open & href_d1;
      cmos_frame_valid <= pix_fire;
      if (pix_fire) cmos_frame_data <= pix_next;
      frame_done       <= vsync_rise && (state == ST_CAPT);
    end
  end

`ifdef CROP_STATS_EN
  logic [PRW-1:0] run_cnt;
  logic [PRW-1:0] cur_prod;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      cur_prod <= '0;
      pix_cnt  <= '0;
      size_err <= 1'b0;
    end else begin
      if (vsync_rise) begin
        // Compare against the window/size that governed the frame just ended.
        if (state == ST_CAPT) begin
          pix_cnt  <= run_cnt;
          size_err <= crop_en_l && (run_cnt != cur_prod);
        end
        run_cnt <= '0;
        if (cfg_load) cur_prod <= prod;
      end else if (pix_fire && (run_cnt != '1)) begin
        run_cnt <= run_cnt + PRW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmos_capture_crop.sv
// Bench for cmos_capture_crop (SKIP_FRAMES = 2, 8-bit bus, 16-bit pixels).
module tb_cmos_capture_crop;
  localparam int SKIP = 2;

  logic        cam_pclk = 1'b0;
  logic        rst_n;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        crop_en;
  logic [10:0] h_start, v_start, crop_w, crop_h;
  logic [10:0] h_pixel, v_pixel;
  logic [27:0] ddr3_addr_max;
  logic        cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, frame_done;
  logic [15:0] cmos_frame_data;
`ifdef CROP_STATS_EN
  logic [21:0] pix_cnt;
  logic        size_err;
`endif

  cmos_capture_crop #(.SKIP_FRAMES(SKIP)) dut (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .crop_en(crop_en), .h_start(h_start), .v_start(v_start),
    .crop_w(crop_w), .crop_h(crop_h), .h_pixel(h_pixel), .v_pixel(v_pixel),
    .ddr3_addr_max(ddr3_addr_max), .cmos_frame_vsync(cmos_frame_vsync),
    .cmos_frame_href(cmos_frame_href), .cmos_frame_valid(cmos_frame_valid),
    .cmos_frame_data(cmos_frame_data), .frame_done(frame_done)
`ifdef CROP_STATS_EN
    , .pix_cnt(pix_cnt), .size_err(size_err)
`endif
  );

  always #5 cam_pclk = ~cam_pclk;

  int unsigned cyc = 0;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  int unsigned obs_stamp[$];
  logic [15:0] obs_data[$];
  int unsigned n_vs = 0, n_hr = 0, n_fd = 0;
  always @(negedge cam_pclk) begin
    if (cmos_frame_valid) begin
      obs_stamp.push_back(cyc);
      obs_data.push_back(cmos_frame_data);
    end
    if (cmos_frame_vsync) n_vs++;
    if (cmos_frame_href)  n_hr++;
    if (frame_done)       n_fd++;
  end

  int total = 0, bad = 0;

  int unsigned exp_stamp[$];
  logic [15:0] exp_data[$];
  int  m_frames, m_hp, m_vp, m_meas_w, m_meas_h, m_strobes, exp_fd;
  bit  m_cap, m_prev_cap;
  bit  l_en;
  int  l_hs, l_vs, l_w, l_h;
  int  exp_pix_cnt;
  bit  exp_size_err;
  int  line_bytes[$];
  bit  chg_en;
  int  chg_hs, chg_vs, chg_w, chg_h;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input int p, input int l);
    return !l_en || (p >= l_hs && p < l_hs + l_w && l >= l_vs && l < l_vs + l_h);
  endfunction

  task automatic model_reset();
    m_frames = 0; m_hp = 0; m_vp = 0; m_meas_w = 0; m_meas_h = 0;
    m_strobes = 0; m_cap = 0; m_prev_cap = 0; exp_fd = 0;
    l_en = 0; l_hs = 0; l_vs = 0; l_w = 0; l_h = 0;
    exp_pix_cnt = 0; exp_size_err = 0;
    exp_stamp.delete(); exp_data.delete();
  endtask

  task automatic model_frame_start();
    m_frames++;
    exp_fd = m_prev_cap ? 1 : 0;
    if (m_prev_cap) begin
      exp_pix_cnt  = m_strobes;
      exp_size_err = l_en && (m_strobes != m_hp * m_vp);
    end
    m_strobes = 0;
    m_cap = (m_frames > SKIP);
    if (m_cap) begin
      l_en = crop_en; l_hs = int'(h_start); l_vs = int'(v_start);
      l_w = int'(crop_w); l_h = int'(crop_h);
      m_hp = l_en ? l_w : m_meas_w;
      m_vp = l_en ? l_h : m_meas_h;
    end
  endtask

  task automatic drive_frame(input string name, input bit mid_change);
    int unsigned s_vs, s_hr, s_fd;
    int hr_total, n, nl;
    logic [7:0] first;
    @(posedge cam_pclk); #1;
    s_vs = n_vs; s_hr = n_hr; s_fd = n_fd;
    model_frame_start();
    repeat (3) begin @(negedge cam_pclk); cam_vsync = 1'b1; end
    @(negedge cam_pclk); cam_vsync = 1'b0;
    repeat (3) @(negedge cam_pclk);
    @(posedge cam_pclk); #1;
    chk({name, " h_pixel"}, h_pixel, m_hp);
    chk({name, " v_pixel"}, v_pixel, m_vp);
    chk({name, " ddr3_addr_max"}, ddr3_addr_max, m_hp * m_vp);
    chk({name, " frame_done pulses"}, n_fd - s_fd, exp_fd);
`ifdef CROP_STATS_EN
    chk({name, " pix_cnt"}, pix_cnt, exp_pix_cnt);
    chk({name, " size_err"}, size_err, exp_size_err);
`endif
    hr_total = 0;
    nl = line_bytes.size();
    first = '0;
    for (int l = 0; l < nl; l++) begin
      if (mid_change && l == nl / 2) begin
        crop_en = chg_en; h_start = 11'(chg_hs); v_start = 11'(chg_vs);
        crop_w = 11'(chg_w); crop_h = 11'(chg_h);
      end
      for (int b = 0; b < line_bytes[l]; b++) begin
        @(negedge cam_pclk);
        cam_href = 1'b1;
        cam_data = 8'($urandom);
        hr_total++;
        if (b % 2 == 0) first = cam_data;
        else if (m_cap && in_win(b / 2, l)) begin
          exp_data.push_back({first, cam_data});
          exp_stamp.push_back(cyc + 2);
          m_strobes++;
        end
      end
      for (int g = 0; g < 4; g++) begin @(negedge cam_pclk); cam_href = 1'b0; end
    end
    repeat (6) @(negedge cam_pclk);
    @(posedge cam_pclk); #1;
    chk({name, " strobe count"}, obs_data.size(), exp_data.size());
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s px%0d data", name, i), obs_data[i], exp_data[i]);
      chk($sformatf("%s px%0d timing", name, i), obs_stamp[i], exp_stamp[i]);
    end
    obs_data.delete(); obs_stamp.delete(); exp_data.delete(); exp_stamp.delete();
    chk({name, " vsync_out cycles"}, n_vs - s_vs, m_cap ? 3 : 0);
    chk({name, " href_out cycles"}, n_hr - s_hr, m_cap ? hr_total : 0);
    m_meas_w = (nl > 0) ? line_bytes[nl-1] / 2 : m_meas_w;
    m_meas_h = nl;
    m_prev_cap = m_cap;
  endtask

  task automatic set_lines(input int nlines, input int nbytes);
    line_bytes.delete();
    for (int i = 0; i < nlines; i++) line_bytes.push_back(nbytes);
  endtask

  task automatic set_win(input bit en, input int hs, input int vs, input int w, input int h);
    crop_en = en; h_start = 11'(hs); v_start = 11'(vs); crop_w = 11'(w); crop_h = 11'(h);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " valid"}, cmos_frame_valid, 0);
    chk({name, " data"}, cmos_frame_data, 0);
    chk({name, " vsync_out"}, cmos_frame_vsync, 0);
    chk({name, " href_out"}, cmos_frame_href, 0);
    chk({name, " frame_done"}, frame_done, 0);
    chk({name, " h_pixel"}, h_pixel, 0);
    chk({name, " v_pixel"}, v_pixel, 0);
    chk({name, " ddr3_addr_max"}, ddr3_addr_max, 0);
`ifdef CROP_STATS_EN
    chk({name, " pix_cnt"}, pix_cnt, 0);
    chk({name, " size_err"}, size_err, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    set_win(0, 0, 0, 0, 0);
    model_reset();
    repeat (4) @(posedge cam_pclk);
    #1 chk_all_zero("reset");
    @(negedge cam_pclk); rst_n = 1'b1;

    // Skip behaviour: three 4x3 frames, only the third is captured.
    set_lines(3, 8);
    drive_frame("skip f1", 0);
    drive_frame("skip f2", 0);
    drive_frame("skip f3", 0);

    // Crop 3x2 window at (2,1) on an 8x4 frame.
    set_win(1, 2, 1, 3, 2);
    set_lines(4, 16);
    drive_frame("crop", 0);
    chk("crop h_pixel const", h_pixel, 3);
    chk("crop v_pixel const", v_pixel, 2);
    chk("crop addr const", ddr3_addr_max, 6);

    // Window changed mid-frame: takes effect only at the next frame.
    chg_en = 1; chg_hs = 0; chg_vs = 0; chg_w = 2; chg_h = 4;
    drive_frame("midchg old", 1);
    drive_frame("midchg new", 0);

    // Zero-width window yields no strobes.
    set_win(1, 0, 0, 0, 3);
    set_lines(3, 8);
    drive_frame("zero w", 0);

    // Odd byte counts: partial pixel discarded, next line unaffected.
    set_win(0, 0, 0, 0, 0);
    line_bytes.delete();
    line_bytes.push_back(5); line_bytes.push_back(4); line_bytes.push_back(6);
    drive_frame("odd bytes", 0);

    // Full-frame measurement: 480 lines, last one 640 pixels wide.
    set_lines(479, 2);
    line_bytes.push_back(1280);
    drive_frame("big", 0);
    set_lines(2, 4);
    drive_frame("after big", 0);
    chk("big h_pixel const", h_pixel, 640);
    chk("big v_pixel const", v_pixel, 480);
    chk("big addr const", ddr3_addr_max, 307200);

    // Random frames and windows.
    for (int r = 0; r < 5; r++) begin
      int nlr;
      nlr = $urandom_range(1, 5);
      line_bytes.delete();
      for (int i = 0; i < nlr; i++) line_bytes.push_back($urandom_range(1, 12));
      set_win(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 4),
              $urandom_range(0, 6), $urandom_range(0, 5));
      drive_frame($sformatf("rand%0d", r), 0);
    end

    // Reset asserted mid-line.
    set_win(1, 0, 0, 4, 4);
    repeat (3) begin @(negedge cam_pclk); cam_vsync = 1'b1; end
    @(negedge cam_pclk); cam_vsync = 1'b0;
    repeat (3) @(negedge cam_pclk);
    repeat (3) begin @(negedge cam_pclk); cam_href = 1'b1; cam_data = 8'($urandom); end
    @(negedge cam_pclk);
    rst_n = 1'b0;
    #1 chk_all_zero("midline reset");
    @(negedge cam_pclk); cam_href = 1'b0; cam_data = '0;
    repeat (3) @(negedge cam_pclk);
    rst_n = 1'b1;
    @(posedge cam_pclk); #1;
    obs_data.delete(); obs_stamp.delete();
    model_reset();
    chk_all_zero("after reset");

    // Re-skip, then a 4x4 window over a 3x3 frame.
    set_lines(3, 6);
    drive_frame("reskip f1", 0);
    drive_frame("reskip f2", 0);
    drive_frame("reskip f3", 0);
    drive_frame("reskip f4", 0);
`ifdef CROP_STATS_EN
    chk("stats pix_cnt const", pix_cnt, 9);
    chk("stats size_err const", size_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
